fsm_state_monitor: RTL and testbench

FSM_STATE_MONITOR -- requirements
Module: fsm_state_monitor

---
 rtl/fsm_state_monitor.sv | 195 +++++++++++++++++++
 tb/tb_fsm_state_monitor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_state_monitor.sv
`default_nettype none
// ============================================================================
// Module      : fsm_state_monitor
// Description : Watches the 2-bit state of an upstream FSM over a window of
//               WINDOW clock cycles opened by a start pulse. Records which
//               states were visited and counts state changes (saturating at
//               255). Flags transitions missing from the LEGAL_TRANS bitmap.
//               At the end of the window it issues a one-cycle done pulse and
//               reports the states that were never entered.
//               Optional dwell/stuck detection is compiled in when the macro
//               MON_STUCK_EN is defined. Otherwise stuck is tied low.
// Ports       : clk          - clock, all logic on the rising edge
//               rst_n        - asynchronous active-low reset
//               state_in     - upstream FSM state, sampled every cycle
//               start        - one-cycle pulse; clears results, opens window
//               visited      - sticky one-hot bitmap of states seen
//               trans_count  - saturating count of state changes
//               illegal      - one-cycle pulse per illegal transition
//               illegal_seen - sticky illegal flag for the window
//               stuck        - state unchanged for STUCK_LIMIT cycles
//               done         - one-cycle pulse at window end
//               unreached    - never-entered states, latched at window end
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_state_monitor #(
    parameter int          WINDOW      = 64,
    parameter logic [15:0] LEGAL_TRANS = 16'h0112,
    parameter int          STUCK_LIMIT = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic [1:0] state_in,
    input  wire logic       start,
    output logic [3:0]      visited,
    output logic [7:0]      trans_count,
    output logic            illegal,
    output logic            illegal_seen,
    output logic            stuck,
    output logic            done,
    output logic [3:0]      unreached
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OBSERVE = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

    localparam logic [15:0] c_WIN_LAST = 16'(WINDOW - 1);

    generate
        if (WINDOW < 2 || WINDOW > 65535 || STUCK_LIMIT < 2 || STUCK_LIMIT > 255) begin : g_param_check
            $error("fsm_state_monitor: WINDOW or STUCK_LIMIT out of range");
        end
    endgenerate

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_done;
    logic [15:0] r_win_cnt;
    logic [1:0]  r_prev;
    logic        r_prev_vld;
    logic [3:0]  r_visited;
    logic [7:0]  r_trans_cnt;
    logic        r_illegal;
    logic        r_illegal_seen;
    logic [3:0]  r_unreached;

    // A start in IDLE or OBSERVE (re)opens the window; it has priority over
    // the ordinary per-cycle sampling of that same cycle.
    logic       w_restart;
    logic       w_sample;
    logic       w_trans;
    logic       w_legal;
    logic       w_last;
    logic [3:0] w_onehot;
    logic [3:0] w_vis_nxt;

    assign w_restart = start && (r_state != ST_REPORT);
    assign w_sample  = (r_state == ST_OBSERVE) && !start;
    assign w_trans   = w_sample && r_prev_vld && (state_in != r_prev);
    assign w_legal   = LEGAL_TRANS[{r_prev, state_in}];
    assign w_last    = w_sample && (r_win_cnt == c_WIN_LAST);
    assign w_onehot  = 4'b0001 << state_in;
    assign w_vis_nxt = r_visited | w_onehot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_OBSERVE;
            end
            ST_OBSERVE: begin
                if (w_last) w_state_nxt = ST_REPORT;
            end
            ST_REPORT: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt      <= 16'd0;
            r_prev         <= 2'd0;
            r_prev_vld     <= 1'b0;
            r_visited      <= 4'd0;
            r_trans_cnt    <= 8'd0;
            r_illegal      <= 1'b0;
            r_illegal_seen <= 1'b0;
            r_unreached    <= 4'd0;
        end else begin
            r_prev    <= state_in;
            r_illegal <= 1'b0;
            if (w_restart) begin
                r_win_cnt      <= 16'd0;
                r_prev_vld     <= 1'b1;
                r_visited      <= 4'd0;
                r_trans_cnt    <= 8'd0;
                r_illegal_seen <= 1'b0;
            end else if (w_sample) begin
                r_win_cnt <= r_win_cnt + 16'd1;
                r_visited <= w_vis_nxt;
                if (w_trans) begin
                    if (r_trans_cnt != 8'hFF) r_trans_cnt <= r_trans_cnt + 8'd1;
                    if (!w_legal) begin
                        r_illegal      <= 1'b1;
                        r_illegal_seen <= 1'b1;
                    end
                end
                // Latch on the final sample so unreached is valid alongside done.
                if (w_last) begin
                    r_win_cnt   <= 16'd0;
                    r_unreached <= ~w_vis_nxt;
                end
            end
        end
    end

`ifdef MON_STUCK_EN
    localparam logic [7:0] c_STUCK_THR = 8'(STUCK_LIMIT - 1);

    logic [7:0] r_dwell;
    logic       r_stuck;
    logic [7:0] w_dwell_inc;

    assign w_dwell_inc = (r_dwell == 8'hFF) ? r_dwell : r_dwell + 8'd1;

    // Dwell counts samples since the last change; the start sample is zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell <= 8'd0;
            r_stuck <= 1'b0;
        end else if (w_restart) begin
            r_dwell <= 8'd0;
            r_stuck <= 1'b0;
        end else if (w_sample && !w_last) begin
            if (w_trans) begin
                r_dwell <= 8'd0;
                r_stuck <= 1'b0;
            end else begin
                r_dwell <= w_dwell_inc;
                r_stuck <= (w_dwell_inc >= c_STUCK_THR);
            end
        end else begin
            r_dwell <= 8'd0;
            r_stuck <= 1'b0;
        end
    end

    assign stuck = r_stuck;
`else
    assign stuck = 1'b0;
`endif

    assign visited      = r_visited;
    assign trans_count  = r_trans_cnt;
    assign illegal      = r_illegal;
    assign illegal_seen = r_illegal_seen;
    assign done         = w_done;
    assign unreached    = r_unreached;

endmodule
`default_nettype wire

// File: tb/tb_fsm_state_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_state_monitor
// Description : Self-checking bench for fsm_state_monitor. It drives two
//               instances (short and long window) with shared stimulus. Each
//               instance is compared every cycle against a window-level
//               reference model, and directed scenarios add constant checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_state_monitor;

    localparam int          c_W0 = 8;
    localparam int          c_W1 = 300;
    localparam int          c_SL = 4;
    localparam logic [15:0] c_LT = 16'h0112;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] state_in = 2'd0;

    logic [3:0] o_vis   [2];
    logic [7:0] o_tc    [2];
    logic       o_ill   [2];
    logic       o_seen  [2];
    logic       o_stuck [2];
    logic       o_done  [2];
    logic [3:0] o_unr   [2];

    fsm_state_monitor #(.WINDOW(c_W0), .LEGAL_TRANS(c_LT), .STUCK_LIMIT(c_SL)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .state_in(state_in), .start(start),
        .visited(o_vis[0]), .trans_count(o_tc[0]), .illegal(o_ill[0]),
        .illegal_seen(o_seen[0]), .stuck(o_stuck[0]), .done(o_done[0]),
        .unreached(o_unr[0]));

    fsm_state_monitor #(.WINDOW(c_W1), .LEGAL_TRANS(c_LT), .STUCK_LIMIT(c_SL)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .state_in(state_in), .start(start),
        .visited(o_vis[1]), .trans_count(o_tc[1]), .illegal(o_ill[1]),
        .illegal_seen(o_seen[1]), .stuck(o_stuck[1]), .done(o_done[1]),
        .unreached(o_unr[1]));

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Window-level model: open window, samples taken, last sample, set of
    // states seen, change count, current run length of one state.
    int         m_win  [2] = '{c_W0, c_W1};
    bit         m_open [2];
    int         m_n    [2];
    int         m_last [2];
    logic [3:0] m_vis  [2];
    int         m_tc   [2];
    bit         m_seen [2];
    bit         m_ill  [2];
    int         m_run  [2];
    bit         m_rd   [2];
    logic [3:0] m_unr  [2];
    logic [15:0] m_lt = c_LT;

    function automatic void model_clear(int d);
        m_open[d] = 0; m_n[d] = 0; m_last[d] = 0; m_vis[d] = 4'd0; m_tc[d] = 0;
        m_seen[d] = 0; m_ill[d] = 0; m_run[d] = 0; m_rd[d] = 0; m_unr[d] = 4'd0;
    endfunction

    function automatic bit model_reporting(int d);
        return m_open[d] && (m_n[d] == m_win[d]) && !m_rd[d];
    endfunction

    function automatic void model_step(int d, bit st, int s);
        bit rep;
        rep = model_reporting(d);
        m_ill[d] = 0;
        if (st && !rep) begin
            m_open[d] = 1; m_n[d] = 0; m_last[d] = s; m_vis[d] = 4'd0;
            m_tc[d] = 0; m_seen[d] = 0; m_run[d] = 1; m_rd[d] = 0;
        end else if (m_open[d] && m_n[d] < m_win[d]) begin
            m_n[d]++;
            m_vis[d][s] = 1'b1;
            if (s != m_last[d]) begin
                m_tc[d]++;
                m_run[d] = 1;
                if (!m_lt[m_last[d] * 4 + s]) begin
                    m_ill[d]  = 1;
                    m_seen[d] = 1;
                end
            end else begin
                m_run[d]++;
            end
            m_last[d] = s;
            if (m_n[d] == m_win[d]) m_unr[d] = ~m_vis[d];
        end else if (rep) begin
            m_rd[d] = 1;
        end
    endfunction

    function automatic bit model_stuck(int d);
`ifdef MON_STUCK_EN
        return m_open[d] && m_n[d] >= 1 && m_n[d] < m_win[d] && m_run[d] >= c_SL;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, act, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk("visited",      d, 32'(o_vis[d]),   32'(m_vis[d]));
            chk("trans_count",  d, 32'(o_tc[d]),    32'((m_tc[d] > 255) ? 255 : m_tc[d]));
            chk("illegal",      d, 32'(o_ill[d]),   32'(m_ill[d]));
            chk("illegal_seen", d, 32'(o_seen[d]),  32'(m_seen[d]));
            chk("stuck",        d, 32'(o_stuck[d]), 32'(model_stuck(d)));
            chk("done",         d, 32'(o_done[d]),  32'(model_reporting(d)));
            chk("unreached",    d, 32'(o_unr[d]),   32'(m_unr[d]));
        end
    endtask

    // One clock cycle: drive at negedge, update model at posedge, check after.
    task automatic cycle(input bit r, input bit st, input int s);
        @(negedge clk);
        rst_n    = r;
        start    = st;
        state_in = 2'(s);
        #1;
        if (!r) begin
            model_clear(0);
            model_clear(1);
            check_all();
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!r) model_clear(d);
            else    model_step(d, st, s);
        end
        #1;
        check_all();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s_prev;
        int s;
        model_clear(0);
        model_clear(1);

        // Reset state
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("rst_visited", 0, 32'(o_vis[0]), 32'd0);
        cycle(1, 0, 0);

        // Alternating 0/1 over an 8-cycle window
        cycle(1, 1, 0);
        for (int i = 0; i < c_W0; i++) cycle(1, 0, i % 2);
        chk("alt_done",      0, 32'(o_done[0]), 32'd1);
        chk("alt_visited",   0, 32'(o_vis[0]),  32'h3);
        chk("alt_unreached", 0, 32'(o_unr[0]),  32'hC);
        chk("alt_tc",        0, 32'(o_tc[0]),   32'd7);
        chk("alt_seen",      0, 32'(o_seen[0]), 32'd0);
        cycle(1, 0, 0);
        chk("alt_done_gone", 0, 32'(o_done[0]), 32'd0);

        // Illegal 0->2, legal 2->0
        cycle(1, 1, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 2);
        chk("ill_pulse", 0, 32'(o_ill[0]), 32'd1);
        cycle(1, 0, 0);
        chk("ill_legal_back", 0, 32'(o_ill[0]),  32'd0);
        chk("ill_sticky",     0, 32'(o_seen[0]), 32'd1);
        // Back-to-back illegal: 0->3, 3->2
        cycle(1, 0, 3);
        cycle(1, 0, 2);
        chk("ill_b2b", 0, 32'(o_ill[0]), 32'd1);
        for (int i = 0; i < 6; i++) cycle(1, 0, 0);

        // Saturation on the long window
        cycle(1, 1, 0);
        for (int i = 0; i < c_W1; i++) cycle(1, 0, (i + 1) % 2);
        chk("sat_done", 1, 32'(o_done[1]), 32'd1);
        chk("sat_tc",   1, 32'(o_tc[1]),   32'd255);
        cycle(1, 0, 0);

        // Reset at window count 3, then a full-length window
        cycle(1, 1, 1);
        for (int i = 0; i < 3; i++) cycle(1, 0, i);
        cycle(0, 0, 1);
        chk("rst_mid_tc", 0, 32'(o_tc[0]), 32'd0);
        cycle(1, 0, 1);
        cycle(1, 1, 1);
        for (int i = 0; i < c_W0 - 1; i++) cycle(1, 0, 1);
        chk("rst_win_early", 0, 32'(o_done[0]), 32'd0);
        cycle(1, 0, 1);
        chk("rst_win_done", 0, 32'(o_done[0]), 32'd1);
        cycle(1, 0, 0);

        // Restart at window count 5
        cycle(1, 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, (i % 2) + 1);
        cycle(1, 1, 3);
        chk("restart_vis", 0, 32'(o_vis[0]), 32'd0);
        chk("restart_tc",  0, 32'(o_tc[0]),  32'd0);
        for (int i = 0; i < c_W0; i++) cycle(1, 0, 3);
        chk("restart_done", 0, 32'(o_done[0]), 32'd1);
        cycle(1, 0, 0);

        // Held state for stuck detection
        cycle(1, 1, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, 1);
`ifdef MON_STUCK_EN
            chk("stuck_hold", 0, 32'(o_stuck[0]), 32'(i >= 3));
`else
            chk("stuck_off", 0, 32'(o_stuck[0]), 32'd0);
`endif
        end
        cycle(1, 0, 0);
        chk("stuck_clear", 0, 32'(o_stuck[0]), 32'd0);

        // Randomized traffic with occasional start/reset and held runs
        s_prev = 0;
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : s_prev;
            cycle(($urandom_range(0, 599) != 0), ($urandom_range(0, 29) == 0), s);
            s_prev = s;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
